lc3_button_conditioner: RTL

//  Upstream front-end for the LC-3 top level: conditions raw DE2 push-buttons and switches.
//  - Synchronises every raw input into the Clk domain.
//  - Debounces the active-low buttons (Run, Continue, ...).
//  - Emits clean active-high levels plus one-cycle press/release pulses.
//  Its outputs drive the Run/Continue inputs of the slc control FSM and the S switch bus.

---
 rtl/lc3_io_pkg.sv | 17 +
 rtl/lc3_debounce_channel.sv | 69 ++++++
 rtl/lc3_button_conditioner.sv | 50 +++++
 3 files changed

// File: rtl/lc3_io_pkg.sv
// Shared constants and event bundle for the LC-3 board I/O conditioning front-end.
`timescale 1ns/1ps
package lc3_io_pkg;

  localparam int BTN_RUN          = 0;
  localparam int BTN_CONTINUE     = 1;
  localparam int DEFAULT_DEBOUNCE = 500000;

  // One conditioned button: stable level plus its single-cycle edge pulses.
  // The release field cannot be named 'release' (reserved word).
  typedef struct packed {
    logic level;
    logic press;
    logic rel;
  } btn_evt_t;

endpackage

// File: rtl/lc3_debounce_channel.sv
// One push-button channel: 2-FF synchroniser, stability counter, registered level and edge pulses.
`timescale 1ns/1ps
module lc3_debounce_channel
  import lc3_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic     Clk,
  input  logic     Reset,
  input  logic     btn_n,
  output btn_evt_t evt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("lc3_debounce_channel: DEBOUNCE_CYCLES must be >= 1");
  end

  logic             meta;
  logic             syn;
  logic             pressed;
  logic [CNT_W-1:0] cnt;
  logic             level;
  logic             press;
  logic             rel;

  // Synchroniser resets to the released (high) state so reset never looks like a press.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      meta <= 1'b1;
      syn  <= 1'b1;
    end else begin
      meta <= btn_n;
      syn  <= meta;
    end
  end

  assign pressed = ~syn;

  // Any return to the accepted level clears the count, so bounces earn no partial credit.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      if (pressed == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= pressed;
        press <= pressed;
        rel   <= ~pressed;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign evt.level = level;
  assign evt.press = press;
  assign evt.rel   = rel;

endmodule

// File: rtl/lc3_button_conditioner.sv
// Board input front-end: debounced active-high buttons with press/release pulses, synchronised switches.
`timescale 1ns/1ps
module lc3_button_conditioner
  import lc3_io_pkg::*;
#(
  parameter int N_BTN           = 2,
  parameter int SW_W            = 16,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_BTN-1:0] btn_n,
  input  logic [SW_W-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [SW_W-1:0]  sw_sync
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_evt_t evt;

    lc3_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .Clk   (Clk),
      .Reset (Reset),
      .btn_n (btn_n[i]),
      .evt   (evt)
    );

    assign btn_level[i]   = evt.level;
    assign btn_press[i]   = evt.press;
    assign btn_release[i] = evt.rel;
  end

  // Switches are level controls read by software, so they only need metastability protection.
  logic [SW_W-1:0] sw_meta;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_raw;
      sw_sync <= sw_meta;
    end
  end

endmodule
